// File: rtl/seg_uart_pkg.sv
// seg_uart_pkg: shared FSM states, requester indices and helpers for the UART byte arbiter
package seg_uart_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;
  localparam logic [1:0] REQ_FAULT = 2'd0;
  localparam logic [1:0] REQ_AUTH  = 2'd1;
  localparam logic [1:0] REQ_TELEM = 2'd2;
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction
endpackage

// File: rtl/rr_arb3.sv
// rr_arb3: combinational round-robin pick among three requesters, starting after last_winner
module rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] last_winner,
  output logic       any,
  output logic [1:0] winner
);
  logic [1:0] s1, s2, s3;
  always_comb begin
    s1 = (last_winner == 2'd2) ? 2'd0 : last_winner + 2'd1;
    s2 = (s1 == 2'd2) ? 2'd0 : s1 + 2'd1;
    s3 = (s2 == 2'd2) ? 2'd0 : s2 + 2'd1;
    any = |req;
    winner = req[s1] ? s1 : req[s2] ? s2 : s3;
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin byte arbiter feeding a UART transmitter with timeout and inter-byte gap
module uart_tx_arb
  import seg_uart_pkg::*;
#(
  parameter int GAP_CYC = 16,
  parameter int TO_CYC  = 32768
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [7:0] req_data2,
  input  logic       tx_done,
  output logic [2:0] gnt,
  output logic [2:0] done,
  output logic       trmt,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       to_err
);
  localparam int TW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_END = TW'(TO_CYC - 1);
  state_t state;
  logic [1:0] last_winner, winner;
  logic any, tx_done_q, tx_rise, to_hit, gap_end;
  logic [TW-1:0] to_cnt, to_nxt;
  logic [GW-1:0] gap_cnt;
  logic [7:0] win_data;
  rr_arb3 u_arb (.req(req), .last_winner(last_winner), .any(any), .winner(winner));
  // Timeout fires on the edge where the counter steps onto TO_CYC-1
  always_comb begin
    win_data = (winner == REQ_FAULT) ? req_data0 : (winner == REQ_AUTH) ? req_data1 : req_data2;
    tx_rise = tx_done & ~tx_done_q;
    to_nxt = to_cnt + 1'b1;
    to_hit = to_nxt == TO_END;
    gap_end = (GAP_CYC == 0) || (gap_cnt == GW'(GAP_CYC - 1));
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_winner <= REQ_TELEM;
      tx_data <= '0;
      to_cnt <= '0;
      gap_cnt <= '0;
      tx_done_q <= 1'b0;
      gnt <= '0;
      done <= '0;
      trmt <= 1'b0;
      to_err <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      gnt <= '0;
      done <= '0;
      trmt <= 1'b0;
      to_err <= 1'b0;
      case (state)
        IDLE: if (any) begin
          gnt <= onehot3(winner);
          tx_data <= win_data;
          last_winner <= winner;
          state <= SEND;
        end
        SEND: begin
          trmt <= 1'b1;
          to_cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (tx_rise) begin
          done <= onehot3(last_winner);
          gap_cnt <= '0;
          state <= GAP;
        end else begin
          if (to_cnt != TO_END) to_cnt <= to_nxt;
          if (to_hit) begin
            to_err <= 1'b1;
            gap_cnt <= '0;
            state <= GAP;
          end
        end
        GAP: if (gap_end) state <= IDLE;
        else gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed scenarios for the arbiter with a short behavioural transmitter model
module tb_uart_tx_arb;
  localparam int BYTE = 30;
  logic clk = 1'b0, rst = 1'b1, tx_done = 1'b0;
  logic [2:0] req = '0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic [2:0] gnt, done, last_done;
  logic trmt, busy, to_err;
  logic [7:0] tx_data;
  int errors = 0, checks = 0, done_cnt = 0, toerr_cnt = 0, cyc = 0, tx_left = 0;
  bit tx_auto = 0;
  logic [7:0] rx_q[$];
  logic [2:0] gnt_q[$];
  int trmt_t[$], done_t[$];

  uart_tx_arb #(.GAP_CYC(16), .TO_CYC(100)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data0(d0), .req_data1(d1), .req_data2(d2),
    .tx_done(tx_done), .gnt(gnt), .done(done), .trmt(trmt), .tx_data(tx_data),
    .busy(busy), .to_err(to_err)
  );

  always #10 clk = ~clk;

  // Event log plus a transmitter stand-in that captures tx_data on trmt and raises tx_done BYTE cycles later
  always @(negedge clk) begin
    cyc++;
    if (|done) begin done_cnt++; last_done = done; done_t.push_back(cyc); end
    if (to_err) toerr_cnt++;
    if (|gnt) gnt_q.push_back(gnt);
    if (trmt) trmt_t.push_back(cyc);
    if (tx_auto) begin
      if (trmt) begin tx_done = 1'b0; rx_q.push_back(tx_data); tx_left = BYTE; end
      else if (tx_left > 0) begin tx_left--; if (tx_left == 0) tx_done = 1'b1; end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    rx_q.delete(); gnt_q.delete(); trmt_t.delete(); done_t.delete();
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 1000) begin tick(); n++; end
    ok = !busy;
  endtask

  task automatic wait_trmt(output bit ok);
    int n = 0;
    while (!trmt && n < 20) begin tick(); n++; end
    ok = trmt;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    tick(); tick();
    checks++;
    if ({gnt, done, trmt, to_err, busy} !== 9'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", {gnt, done, trmt, to_err, busy}); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data); end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: busy=%b want 0", busy); end
  endtask

  task automatic test_single();
    bit ok;
    int base = done_cnt;
    tx_auto = 1; rx_q.delete();
    d1 = 8'h67; req = 3'b010;
    tick();
    checks++;
    if (gnt !== 3'b010 || tx_data !== 8'h67) begin errors++; $display("FAIL single_gnt: gnt=%b data=%h want 010/67", gnt, tx_data); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    req = '0;
    tick();
    checks++;
    if ({trmt, gnt} !== 4'b1000) begin errors++; $display("FAIL single_trmt: trmt,gnt=%b want 1000", {trmt, gnt}); end
    wait_idle(ok);
    checks++;
    if (!ok || done_cnt - base != 1 || last_done !== 3'b010) begin errors++; $display("FAIL single_done: idle=%0d pulses=%0d last=%b want 1/1/010", ok, done_cnt - base, last_done); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h67) begin errors++; $display("FAIL single_rx: n=%0d want 1 byte 67", rx_q.size()); end
  endtask

  task automatic test_all3();
    bit ok;
    int n = 0, base;
    do_reset();
    base = done_cnt;
    d0 = 8'hF0; d1 = 8'h67; d2 = 8'h73; req = 3'b111;
    while (done_cnt - base < 3 && n < 2000) begin
      tick(); n++;
      req = req & ~gnt;
    end
    checks++;
    if (done_cnt - base != 3) begin errors++; $display("FAIL all3_bound: done pulses=%0d want 3", done_cnt - base); end
    checks++;
    if (rx_q.size() != 3 || {rx_q[0], rx_q[1], rx_q[2]} !== 24'hF06773) begin errors++; $display("FAIL all3_order: n=%0d want F0,67,73", rx_q.size()); end
    checks++;
    if (gnt_q.size() != 3 || {gnt_q[0], gnt_q[1], gnt_q[2]} !== 9'b001_010_100) begin errors++; $display("FAIL all3_gnt: n=%0d want 001,010,100", gnt_q.size()); end
    checks++;
    if (trmt_t.size() != 3 || done_t.size() != 3 || trmt_t[1] - done_t[0] != 18 || trmt_t[2] - done_t[1] != 18) begin
      errors++; $display("FAIL all3_gap: done-to-trmt spacing wrong, want 18 cycles each");
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL all3_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_fairness();
    bit ok;
    int n = 0;
    do_reset();
    d0 = 8'hA0; d2 = 8'hC2; req = 3'b101;
    while (gnt_q.size() < 4 && n < 3000) begin tick(); n++; end
    req = '0;
    wait_idle(ok);
    checks++;
    if (gnt_q.size() != 4 || {gnt_q[0], gnt_q[1], gnt_q[2], gnt_q[3]} !== 12'b001_100_001_100) begin errors++; $display("FAIL fair_gnt: n=%0d want 001,100,001,100", gnt_q.size()); end
    checks++;
    if (!ok || rx_q.size() != 4 || {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'hA0C2A0C2) begin errors++; $display("FAIL fair_rx: n=%0d want A0,C2,A0,C2", rx_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    int k = 0, bd, bt;
    tx_auto = 0; tx_done = 1'b0;
    do_reset();
    bd = done_cnt; bt = toerr_cnt;
    d0 = 8'h11; req = 3'b001;
    tick();
    req = '0;
    wait_trmt(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_trmt: trmt=%b want 1", trmt); end
    while (!to_err && k < 300) begin tick(); k++; end
    checks++;
    if (k != 99) begin errors++; $display("FAIL to_latency: got %0d cycles want 99", k); end
    tick();
    checks++;
    if (to_err !== 1'b0) begin errors++; $display("FAIL to_pulse: to_err=%b want 0", to_err); end
    wait_idle(ok);
    checks++;
    if (!ok || done_cnt != bd || toerr_cnt - bt != 1) begin errors++; $display("FAIL to_result: idle=%0d done=%0d to_err=%0d want 1/0/1", ok, done_cnt - bd, toerr_cnt - bt); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int bd, bt;
    tx_auto = 0; tx_done = 1'b0;
    do_reset();
    d0 = 8'h3C; req = 3'b001;
    tick();
    req = '0;
    wait_trmt(ok);
    repeat (50) tick();
    bd = done_cnt; bt = toerr_cnt;
    rst = 1'b1;
    tick();
    checks++;
    if (!ok || {gnt, done, trmt, to_err, busy} !== 9'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mid_reset: ctrl=%b data=%h want 0/00", {gnt, done, trmt, to_err, busy}, tx_data); end
    rst = 1'b0;
    repeat (150) tick();
    checks++;
    if (done_cnt != bd || toerr_cnt != bt) begin errors++; $display("FAIL mid_abandon: done=%0d to_err=%0d want 0/0", done_cnt - bd, toerr_cnt - bt); end
    tx_auto = 1;
    d0 = 8'h5A; d1 = 8'h6B; req = 3'b011;
    tick();
    checks++;
    if (gnt !== 3'b001 || tx_data !== 8'h5A) begin errors++; $display("FAIL mid_regrant: gnt=%b data=%h want 001/5A", gnt, tx_data); end
    req = '0;
    wait_idle(ok);
    checks++;
    if (!ok || done_cnt - bd != 1) begin errors++; $display("FAIL mid_finish: idle=%0d done=%0d want 1/1", ok, done_cnt - bd); end
  endtask

  task automatic test_stale();
    bit ok;
    int bd;
    tx_auto = 0; tx_done = 1'b1;
    do_reset();
    bd = done_cnt;
    d1 = 8'h99; req = 3'b010;
    tick();
    req = '0;
    wait_trmt(ok);
    repeat (20) tick();
    checks++;
    if (!ok || done_cnt != bd) begin errors++; $display("FAIL stale_high: done pulses=%0d want 0", done_cnt - bd); end
    tx_done = 1'b0;
    tick(); tick();
    checks++;
    if (done_cnt != bd) begin errors++; $display("FAIL stale_low: done pulses=%0d want 0", done_cnt - bd); end
    tx_done = 1'b1;
    tick();
    checks++;
    if (done !== 3'b010) begin errors++; $display("FAIL stale_edge: done=%b want 010", done); end
    tick();
    checks++;
    if (done !== 3'b000) begin errors++; $display("FAIL stale_pulse: done=%b want 000", done); end
    wait_idle(ok);
    tx_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all3();
    test_fairness();
    test_timeout();
    test_reset_mid_wait();
    test_stale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
